dmem_responder: RTL and testbench

Data-memory responder for the processor core's load/store port. It accepts one request at a time from the processor (the initiator), waits a fixed, configurable number of cycles, performs the byte-masked read or write, and returns a response under a valid/ready handshake. It sits beside `Processor_Top` and lets the bench and the SoC model realistic memory wait states.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, default data width and the legal wait-state range.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DMEM_DATA_W_DEFAULT = 32;
    localparam int LATENCY_MIN         = 1;
    localparam int LATENCY_MAX         = 15;

    function automatic bit latency_ok(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the processor (master) and the memory responder
// (slave).
interface dmem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // A beat transfers on a rising edge where valid and ready are both high;
    // once valid is raised it stays high, with its payload stable, until that edge.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage with byte-enable write and synchronous read, one access per
// strobe. Contents are deliberately not reset.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // The caller only strobes in-range addresses.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: latches one request, waits LATENCY
// cycles, performs the access, then holds the response until accepted.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = DMEM_DATA_W_DEFAULT,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_responder_if.slave      bus,
    output state_e               state_o
);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("dmem_responder: LATENCY out of range 1..15");
    end

    localparam logic [3:0]        CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic                  err_q, err_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  mem_en;
    logic                  oob;
    logic [DATA_W-1:0]     arr_rdata;

    assign oob = ({1'b0, addr_q} >= DEPTH_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        mem_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Commit on the edge that enters RESP so a reset in WAIT drops the write.
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    mem_en   = !oob;
                    err_d    = oob;
                    rd_sel_d = !we_q && !oob;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d  = ST_IDLE;
                    err_d    = 1'b0;
                    rd_sel_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (we_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (arr_rdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rd_sel_q ? arr_rdata : '0;
    assign bus.rsp_err   = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with DEPTH=200, LATENCY=2.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic   clk;
    logic   rst_n;
    state_e state;
    int     errors = 0;
    int     checks = 0;

    dmem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_responder #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .DEPTH   (200),
        .LATENCY (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: latency, response stability under back-pressure and
    // the req_ready release after the response handshake are checked here.
    task automatic do_req(input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int hold, input bit noise,
                          output logic [31:0] rdata, output logic err);
        int guard;
        int lat;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (noise) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 8'h10;
            bus.req_wdata = 32'hFFFF_FFFF;
            bus.req_be    = 4'hF;
        end
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (noise) bus.req_valid = ~bus.req_valid;
        end
        check("latency", 32'(lat), 32'd2);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata, rdata);
            check("hold_err", 32'(bus.rsp_err), 32'(err));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #30;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_req_ready", 32'(bus.req_ready), 32'd1);
            check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("idle_rsp_rdata", bus.rsp_rdata, 32'd0);
            check("idle_rsp_err", 32'(bus.rsp_err), 32'd0);
        end

        do_req(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er);
        check("wr10_rdata", rd, 32'd0);
        check("wr10_err", 32'(er), 32'd0);
        do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("rd10_rdata", rd, 32'hDEAD_BEEF);
        check("rd10_err", 32'(er), 32'd0);

        do_req(1'b1, 8'h20, 32'hAAAA_AAAA, 4'hF, 0, 1'b0, rd, er);
        do_req(1'b1, 8'h20, 32'h1122_3344, 4'b0101, 0, 1'b0, rd, er);
        do_req(1'b0, 8'h20, 32'h0, 4'h0, 1, 1'b0, rd, er);
        check("rd20_be_merge", rd, 32'hAA22_AA44);

        do_req(1'b0, 8'hC8, 32'h0, 4'h0, 5, 1'b0, rd, er);
        check("oob_rdata", rd, 32'd0);
        check("oob_err", 32'(er), 32'd1);
        do_req(1'b1, 8'hC8, 32'h5A5A_5A5A, 4'hF, 0, 1'b0, rd, er);
        check("oob_wr_err", 32'(er), 32'd1);

        do_req(1'b1, 8'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("be0_err", 32'(er), 32'd0);
        do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("be0_unchanged", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 8'h40, 32'h1234_5678, 4'hF, 2, 1'b1, rd, er);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("noise_no_extra_rsp", 32'(bus.rsp_valid), 32'd0);
            check("noise_idle", 32'(state), 32'(ST_IDLE));
        end
        do_req(1'b0, 8'h40, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("noise_latched_data", rd, 32'h1234_5678);
        do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("noise_other_addr", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 8'h30, 32'h0, 4'hF, 0, 1'b0, rd, er);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 8'h30;
        bus.req_wdata = 32'h5555_5555;
        bus.req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_in_wait", 32'(state), 32'(ST_WAIT));
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        do_req(1'b0, 8'h30, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("mid_rst_dropped_write", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
